// File: rtl/gshare_predictor.sv
// Gshare branch predictor: 2-bit PHT indexed by PC^GHR plus a direct-mapped BTB.
// Predicts combinationally from if_PC, trains from EX-resolved branches, counts branches/mispredicts.
module gshare_predictor #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_ENTRIES = 256,
  parameter int GHR_WIDTH   = 8,
  localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] if_PC,
  output logic                  if_pred,
  output logic [DATA_WIDTH-1:0] if_pred_target,
  output logic [IDX_W-1:0]      if_pred_idx,
  input  logic                  ex_update,
  input  logic [DATA_WIDTH-1:0] ex_PC,
  input  logic [IDX_W-1:0]      ex_pred_idx,
  input  logic                  ex_pred,
  input  logic                  ex_taken,
  input  logic [DATA_WIDTH-1:0] ex_target,
  output logic [31:0]           branch_count,
  output logic [31:0]           mispredict_count
);

  localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

  logic [1:0]            pht_q       [NUM_ENTRIES];
  logic                  btb_valid_q [NUM_ENTRIES];
  logic [TAG_W-1:0]      btb_tag_q   [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0] btb_tgt_q   [NUM_ENTRIES];

  logic [GHR_WIDTH-1:0]  ghr_q, ghr_d;
  logic [31:0]           branch_count_q, branch_count_d;
  logic [31:0]           mispredict_count_q, mispredict_count_d;

  logic [IDX_W-1:0]      if_btb_idx, ex_btb_idx;
  logic                  if_hit;
  logic [1:0]            pht_cur, pht_new;
  logic                  mispredict;
  logic                  unused_pc_bits;

  assign unused_pc_bits = ^{if_PC[1:0], ex_PC[1:0]};

  always_comb begin
    if_btb_idx     = if_PC[IDX_W+1:2];
    if_pred_idx    = if_btb_idx ^ IDX_W'(ghr_q);
    if_hit         = btb_valid_q[if_btb_idx] && (btb_tag_q[if_btb_idx] == if_PC[DATA_WIDTH-1:IDX_W+2]);
    if_pred        = 1'b0;
    if_pred_target = '0;
    if (!reset && if_hit) begin
      if_pred        = pht_q[if_pred_idx][1];
      if_pred_target = btb_tgt_q[if_btb_idx];
    end
  end

  always_comb begin
    ex_btb_idx = ex_PC[IDX_W+1:2];
    pht_cur    = pht_q[ex_pred_idx];
    pht_new    = pht_cur;
    if (ex_taken && pht_cur != 2'b11)
      pht_new = pht_cur + 2'd1;
    else if (!ex_taken && pht_cur != 2'b00)
      pht_new = pht_cur - 2'd1;

    // Target compare reads the BTB before this cycle's write lands.
    mispredict = (ex_pred != ex_taken) ||
                 (ex_pred && ex_taken && (btb_tgt_q[ex_btb_idx] != ex_target));

    ghr_d              = ghr_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (ex_update) begin
      ghr_d          = {ghr_q[GHR_WIDTH-2:0], ex_taken};
      branch_count_d = branch_count_q + 32'd1;
      if (mispredict)
        mispredict_count_d = mispredict_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        pht_q[i[IDX_W-1:0]]       <= 2'b01;
        btb_valid_q[i[IDX_W-1:0]] <= 1'b0;
        btb_tag_q[i[IDX_W-1:0]]   <= '0;
        btb_tgt_q[i[IDX_W-1:0]]   <= '0;
      end
      ghr_q              <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      ghr_q              <= ghr_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
      if (ex_update) begin
        pht_q[ex_pred_idx] <= pht_new;
        if (ex_taken) begin
          btb_valid_q[ex_btb_idx] <= 1'b1;
          btb_tag_q[ex_btb_idx]   <= ex_PC[DATA_WIDTH-1:IDX_W+2];
          btb_tgt_q[ex_btb_idx]   <= ex_target;
        end
      end
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: vector table plus hand sequences for
// saturation and same-cycle behaviour, checked through an expectation queue.
module tb_gshare_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_PC;
  logic        if_pred;
  logic [31:0] if_pred_target;
  logic [7:0]  if_pred_idx;
  logic        ex_update;
  logic [31:0] ex_PC;
  logic [7:0]  ex_pred_idx;
  logic        ex_pred;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  always #5 clk = ~clk;

  gshare_predictor #(.DATA_WIDTH(32), .NUM_ENTRIES(256), .GHR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .if_PC(if_PC), .if_pred(if_pred),
    .if_pred_target(if_pred_target), .if_pred_idx(if_pred_idx),
    .ex_update(ex_update), .ex_PC(ex_PC), .ex_pred_idx(ex_pred_idx),
    .ex_pred(ex_pred), .ex_taken(ex_taken), .ex_target(ex_target),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  typedef struct {
    logic        rst, upd;
    logic [31:0] ex_pc;
    logic [7:0]  ex_idx;
    logic        ex_pred, ex_taken;
    logic [31:0] ex_tgt, if_pc;
    logic        exp_pred;
    logic [31:0] exp_tgt;
    logic [7:0]  exp_idx;
    logic [31:0] exp_bc, exp_mc;
  } vec_t;

  typedef struct {
    int          tag;
    logic        pred;
    logic [31:0] tgt;
    logic [7:0]  idx;
    logic [31:0] bc, mc;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   step_no = 0;
  logic [31:0] run_bc = 0;
  logic [31:0] run_mc = 0;
  vec_t tbl[20];

  function automatic vec_t mk(logic rst, logic upd, logic [31:0] ex_pc, logic [7:0] ex_idx,
                              logic ep, logic et, logic [31:0] ex_tgt, logic [31:0] if_pc,
                              logic xp, logic [31:0] xt, logic [7:0] xi,
                              logic [31:0] xbc, logic [31:0] xmc);
    vec_t v;
    v.rst = rst; v.upd = upd; v.ex_pc = ex_pc; v.ex_idx = ex_idx;
    v.ex_pred = ep; v.ex_taken = et; v.ex_tgt = ex_tgt; v.if_pc = if_pc;
    v.exp_pred = xp; v.exp_tgt = xt; v.exp_idx = xi; v.exp_bc = xbc; v.exp_mc = xmc;
    return v;
  endfunction

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", nm, tag, act, exp);
  endtask

  task automatic step(input vec_t v);
    exp_t e, got;
    @(posedge clk);
    #1;
    reset = v.rst; ex_update = v.upd; ex_PC = v.ex_pc; ex_pred_idx = v.ex_idx;
    ex_pred = v.ex_pred; ex_taken = v.ex_taken; ex_target = v.ex_tgt; if_PC = v.if_pc;
    e.tag = step_no; e.pred = v.exp_pred; e.tgt = v.exp_tgt; e.idx = v.exp_idx;
    e.bc = v.exp_bc; e.mc = v.exp_mc;
    sb.push_back(e);
    step_no++;
    @(negedge clk);
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard empty at step %0d", step_no);
    end else begin
      got = sb.pop_front();
      chk("if_pred",          got.tag, {31'd0, if_pred},  {31'd0, got.pred});
      chk("if_pred_target",   got.tag, if_pred_target,    got.tgt);
      chk("if_pred_idx",      got.tag, {24'd0, if_pred_idx}, {24'd0, got.idx});
      chk("branch_count",     got.tag, branch_count,      got.bc);
      chk("mispredict_count", got.tag, mispredict_count,  got.mc);
    end
  endtask

  // Hand-sequence step: ex_pred is always 0, so a taken update is a mispredict.
  task automatic sat(input logic upd, input logic [31:0] pc, input logic [7:0] idx,
                     input logic taken, input logic [31:0] tgt, input logic [31:0] if_pc,
                     input logic xp, input logic [31:0] xt, input logic [7:0] xi);
    step(mk(1'b0, upd, pc, idx, 1'b0, taken, tgt, if_pc, xp, xt, xi, run_bc, run_mc));
    if (upd) begin
      run_bc = run_bc + 1;
      if (taken) run_mc = run_mc + 1;
    end
  endtask

  // Eight not-taken updates on an unrelated entry flush the history back to zero.
  task automatic clr(input logic [7:0] g0);
    logic [7:0] g;
    g = g0;
    for (int k = 0; k < 8; k++) begin
      sat(1'b1, 32'h40, 8'h10, 1'b0, 32'h0, 32'h14, 1'b0, 32'h80, 8'h05 ^ g);
      g = {g[6:0], 1'b0};
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ex_update = 1'b0; ex_PC = '0; ex_pred_idx = '0;
    ex_pred = 1'b0; ex_taken = 1'b0; ex_target = '0; if_PC = 32'h100;
    repeat (2) @(posedge clk);

    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h100, 0, 0, 8'h40, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 0, 8'h40, 0, 0);
    tbl[2]  = mk(0, 1, 32'h100, 8'h40, 0, 1, 32'h200, 32'h100, 0, 0, 8'h40, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 32'h200, 8'h41, 1, 1);
    for (int k = 0; k < 8; k++)
      tbl[4+k] = mk(0, 1, 32'h40, 8'h10, 0, 0, 0, 32'h100, 0, 32'h200,
                    8'h40 ^ (8'h01 << k), 32'(1 + k), 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 32'h100, 1, 32'h200, 8'h40, 9, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 32'h500, 0, 0, 8'h40, 9, 1);
    tbl[14] = mk(0, 1, 32'h100, 8'h40, 1, 1, 32'h300, 32'h100, 1, 32'h200, 8'h40, 9, 1);
    tbl[15] = mk(0, 1, 32'h100, 8'h41, 1, 1, 32'h300, 32'h100, 0, 32'h300, 8'h41, 10, 2);
    tbl[16] = mk(0, 1, 32'h100, 8'h43, 1, 0, 0, 32'h100, 0, 32'h300, 8'h43, 11, 2);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 32'h300, 8'h46, 12, 3);
    tbl[18] = mk(1, 1, 32'h100, 8'h46, 0, 1, 32'h999, 32'h100, 0, 0, 8'h46, 12, 3);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 0, 8'h40, 0, 0);

    for (int i = 0; i < 20; i++) step(tbl[i]);

    // Warm entry 5 to saturation, then walk it down through the floor.
    sat(1, 32'h14, 8'h05, 1, 32'h80, 32'h14, 0, 32'h0,  8'h05);
    sat(1, 32'h14, 8'h05, 1, 32'h80, 32'h14, 0, 32'h80, 8'h04);
    sat(1, 32'h14, 8'h05, 1, 32'h80, 32'h14, 0, 32'h80, 8'h06);
    sat(1, 32'h14, 8'h05, 1, 32'h80, 32'h14, 0, 32'h80, 8'h02);
    clr(8'h0F);
    sat(0, 0, 0, 0, 0, 32'h14, 1, 32'h80, 8'h05);
    sat(1, 32'h14, 8'h05, 0, 0, 32'h14, 1, 32'h80, 8'h05);
    sat(1, 32'h14, 8'h05, 0, 0, 32'h14, 1, 32'h80, 8'h05);
    sat(0, 0, 0, 0, 0, 32'h14, 0, 32'h80, 8'h05);
    sat(1, 32'h14, 8'h05, 0, 0, 32'h14, 0, 32'h80, 8'h05);
    sat(1, 32'h14, 8'h05, 0, 0, 32'h14, 0, 32'h80, 8'h05);
    sat(1, 32'h14, 8'h05, 0, 0, 32'h14, 0, 32'h80, 8'h05);
    sat(1, 32'h14, 8'h05, 1, 32'h80, 32'h14, 0, 32'h80, 8'h05);
    clr(8'h01);
    sat(0, 0, 0, 0, 0, 32'h14, 0, 32'h80, 8'h05);
    sat(1, 32'h14, 8'h05, 1, 32'h80, 32'h14, 0, 32'h80, 8'h05);
    clr(8'h01);
    sat(0, 0, 0, 0, 0, 32'h14, 1, 32'h80, 8'h05);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
